// File: rtl/stream_align_ctrl.sv
// Batch scheduler and per-lane skew limiter in front of a stream-to-pipe aligner.
// Optional stall counter on perf_stall is built only with STREAM_ALIGN_CTRL_PERF_EN defined.
module stream_align_ctrl #(
  parameter int unsigned IN_NB = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             s_rst_n,
  input  logic             ctrl_start,
  input  logic [CNT_W-1:0] ctrl_len,
  input  logic             ctrl_abort,
  output logic             ctrl_busy,
  output logic             ctrl_done,
  output logic             ctrl_aborted,
  input  logic [IN_NB-1:0] src_vld,
  output logic [IN_NB-1:0] src_rdy,
  output logic [IN_NB-1:0] aln_vld,
  input  logic [IN_NB-1:0] aln_rdy,
  input  logic             aln_avail,
  output logic             error_desync,
  output logic [31:0]      perf_stall
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StRun      = 3'd1;
  localparam logic [2:0] StDrain    = 3'd2;
  localparam logic [2:0] StEqualize = 3'd3;
  localparam logic [2:0] StDone     = 3'd4;

  localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] acc_q [IN_NB];
  logic [CNT_W-1:0] acc_d [IN_NB];
  logic [CNT_W-1:0] acc_inc [IN_NB];
  logic [CNT_W-1:0] lead [IN_NB];
  logic             aborted_q, aborted_d;
  logic             error_q, error_d;

  logic [IN_NB-1:0] en;
  logic [IN_NB-1:0] hs;
  logic [CNT_W-1:0] min_acc;
  logic [CNT_W-1:0] max_acc_inc;
  logic             all_len;
  logic             all_tgt;
  logic             stall;

  always_comb begin
    en    = '0;
    stall = 1'b0;
    for (int i = 0; i < IN_NB; i++) begin
      // acc never falls below out_cnt, so the difference cannot wrap
      lead[i] = acc_q[i] - out_cnt_q;
      case (state_q)
        StRun:      en[i] = (acc_q[i] < len_q) && (lead[i] < DepthC);
        StEqualize: en[i] = acc_q[i] < tgt_q;
        default:    en[i] = 1'b0;
      endcase
      if (state_q == StRun && src_vld[i] && acc_q[i] < len_q && lead[i] == DepthC) begin
        stall = 1'b1;
      end
    end
  end

  assign aln_vld = src_vld & en;
  assign src_rdy = aln_rdy & en;
  assign hs      = src_vld & src_rdy;

  always_comb begin
    min_acc     = acc_q[0];
    max_acc_inc = '0;
    all_len     = 1'b1;
    all_tgt     = 1'b1;
    for (int i = 0; i < IN_NB; i++) begin
      acc_inc[i] = acc_q[i] + CNT_W'(hs[i]);
      if (acc_q[i] < min_acc) min_acc = acc_q[i];
      if (acc_inc[i] > max_acc_inc) max_acc_inc = acc_inc[i];
      if (acc_q[i] != len_q) all_len = 1'b0;
      if (acc_q[i] != tgt_q) all_tgt = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    tgt_d     = tgt_q;
    aborted_d = aborted_q;
    out_cnt_d = out_cnt_q + CNT_W'(aln_avail);
    for (int i = 0; i < IN_NB; i++) acc_d[i] = acc_inc[i];
    // An aligned word with no lane ahead of the output means the aligner lost lock
    error_d = error_q | (aln_avail & ((state_q == StIdle) | (out_cnt_q == min_acc)));

    case (state_q)
      StIdle: begin
        if (ctrl_start) begin
          len_d     = ctrl_len;
          out_cnt_d = '0;
          error_d   = 1'b0;
          aborted_d = 1'b0;
          for (int i = 0; i < IN_NB; i++) acc_d[i] = '0;
          state_d = (ctrl_len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (ctrl_abort) begin
          // Target includes handshakes landing in the abort cycle itself
          tgt_d     = max_acc_inc;
          aborted_d = 1'b1;
          state_d   = StEqualize;
        end else if (all_len) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_cnt_q == len_q) state_d = StDone;
      end
      StEqualize: begin
        if (all_tgt) begin
          len_d   = tgt_q;
          state_d = StDrain;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      state_q   <= StIdle;
      len_q     <= '0;
      tgt_q     <= '0;
      out_cnt_q <= '0;
      aborted_q <= 1'b0;
      error_q   <= 1'b0;
      for (int i = 0; i < IN_NB; i++) acc_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      tgt_q     <= tgt_d;
      out_cnt_q <= out_cnt_d;
      aborted_q <= aborted_d;
      error_q   <= error_d;
      for (int i = 0; i < IN_NB; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign ctrl_busy    = (state_q != StIdle);
  assign ctrl_done    = (state_q == StDone);
  assign ctrl_aborted = ctrl_done & aborted_q;
  assign error_desync = error_q;

`ifdef STREAM_ALIGN_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      perf_q <= '0;
    end else if (state_q == StIdle && ctrl_start) begin
      perf_q <= '0;
    end else if (stall && perf_q != 32'hFFFF_FFFF) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall = perf_q;
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_stream_align_ctrl.sv
// Directed bench for stream_align_ctrl: lane sources and an echoing aligner are modelled
// inside the stimulus process; inputs change on negedge, handshakes are predicted before posedge.
module tb_stream_align_ctrl;

  logic        clk;
  logic        s_rst_n;
  logic        ctrl_start;
  logic [15:0] ctrl_len;
  logic        ctrl_abort;
  logic        ctrl_busy;
  logic        ctrl_done;
  logic        ctrl_aborted;
  logic [3:0]  src_vld;
  logic [3:0]  src_rdy;
  logic [3:0]  aln_vld;
  logic [3:0]  aln_rdy;
  logic        aln_avail;
  logic        error_desync;
  logic [31:0] perf_stall;

  int checks = 0;
  int errors = 0;
  int acc_m [4];
  int quota [4];
  int out_m;
  int done_cnt;
  bit last_aborted;
  bit aligner_on;
  bit force_avail;

  stream_align_ctrl dut (
    .clk          (clk),
    .s_rst_n      (s_rst_n),
    .ctrl_start   (ctrl_start),
    .ctrl_len     (ctrl_len),
    .ctrl_abort   (ctrl_abort),
    .ctrl_busy    (ctrl_busy),
    .ctrl_done    (ctrl_done),
    .ctrl_aborted (ctrl_aborted),
    .src_vld      (src_vld),
    .src_rdy      (src_rdy),
    .aln_vld      (aln_vld),
    .aln_rdy      (aln_rdy),
    .aln_avail    (aln_avail),
    .error_desync (error_desync),
    .perf_stall   (perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive sources/aligner, predict the posedge, return on the following negedge.
  task automatic step();
    int mn;
    mn = acc_m[0];
    for (int i = 0; i < 4; i++) begin
      src_vld[i] = (acc_m[i] < quota[i]);
      if (acc_m[i] < mn) mn = acc_m[i];
    end
    aln_avail = force_avail || (aligner_on && (mn > out_m));
    #1;
    for (int i = 0; i < 4; i++) if (src_vld[i] && src_rdy[i]) acc_m[i]++;
    if (aln_avail) out_m++;
    if (ctrl_done) begin
      done_cnt++;
      last_aborted = ctrl_aborted;
    end
    @(negedge clk);
  endtask

  task automatic start(input int len);
    ctrl_start = 1'b1;
    ctrl_len   = 16'(len);
    for (int i = 0; i < 4; i++) acc_m[i] = 0;
    out_m    = 0;
    done_cnt = 0;
    step();
    ctrl_start = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    for (int n = 0; n < budget && done_cnt == 0; n++) step();
    chk("done_seen", done_cnt, 1);
    chk("busy_after_done", ctrl_busy, 0);
  endtask

  task automatic chk_acc(input string tag, input int v0, input int v1, input int v2,
                         input int v3);
    chk({tag, "_acc0"}, acc_m[0], v0);
    chk({tag, "_acc1"}, acc_m[1], v1);
    chk({tag, "_acc2"}, acc_m[2], v2);
    chk({tag, "_acc3"}, acc_m[3], v3);
  endtask

  function automatic bit at_quota();
    bit r;
    r = 1'b1;
    for (int i = 0; i < 4; i++) if (acc_m[i] != quota[i]) r = 1'b0;
    return r;
  endfunction

  initial begin
    s_rst_n     = 1'b0;
    ctrl_start  = 1'b0;
    ctrl_len    = '0;
    ctrl_abort  = 1'b0;
    src_vld     = '0;
    aln_rdy     = 4'hF;
    aln_avail   = 1'b0;
    aligner_on  = 1'b1;
    force_avail = 1'b0;
    out_m       = 0;
    done_cnt    = 0;
    for (int i = 0; i < 4; i++) begin
      acc_m[i] = 0;
      quota[i] = 1000;
    end
    @(negedge clk);
    step();
    step();
    s_rst_n = 1'b1;

    // Reset state, sources valid but nothing enabled
    chk("rst_busy", ctrl_busy, 0);
    chk("rst_done", ctrl_done, 0);
    chk("rst_aborted", ctrl_aborted, 0);
    chk("rst_error", error_desync, 0);
    chk("rst_src_rdy", src_rdy, 0);
    chk("rst_aln_vld", aln_vld, 0);
    chk("rst_perf", perf_stall, 0);

    // Zero length: done one cycle after start, no lane enabled
    start(0);
    chk("zero_done", ctrl_done, 1);
    chk("zero_busy", ctrl_busy, 1);
    chk("zero_aborted", ctrl_aborted, 0);
    chk("zero_src_rdy", src_rdy, 0);
    step();
    chk("zero_done_fall", ctrl_done, 0);
    chk("zero_busy_fall", ctrl_busy, 0);
    chk("zero_done_cnt", done_cnt, 1);

    // Abort outside RUN is ignored
    ctrl_abort = 1'b1;
    step();
    ctrl_abort = 1'b0;
    chk("idle_abort_busy", ctrl_busy, 0);

    // Nominal batch of 100
    start(100);
    chk("nom_busy", ctrl_busy, 1);
    run_to_done(600);
    chk_acc("nom", 100, 100, 100, 100);
    chk("nom_out", out_m, 100);
    chk("nom_aborted", last_aborted, 0);
    chk("nom_error", error_desync, 0);

    // Lead limit: only lane 0 supplies
    quota[0] = 1000;
    quota[1] = 0;
    quota[2] = 0;
    quota[3] = 0;
    start(20);
    repeat (15) step();
    chk("lead_acc0", acc_m[0], 8);
    chk("lead_rdy0", src_rdy[0], 0);
    chk("lead_vld0", aln_vld[0], 0);
    chk("lead_out", out_m, 0);
    for (int i = 1; i < 4; i++) quota[i] = 1000;
    step();
    chk("lead_rdy0_hold", src_rdy[0], 0);
    step();
    chk("lead_rdy0_back", src_rdy[0], 1);
    run_to_done(300);
    chk_acc("lead", 20, 20, 20, 20);
    chk("lead_error", error_desync, 0);
`ifdef STREAM_ALIGN_CTRL_PERF_EN
    chk("lead_perf_nonzero", (perf_stall != 0) ? 1 : 0, 1);
`else
    chk("lead_perf_zero", perf_stall, 0);
`endif

    // Abort with skew {10,7,9,10}
    quota[0] = 10;
    quota[1] = 7;
    quota[2] = 9;
    quota[3] = 10;
    start(50);
    for (int n = 0; n < 100 && !at_quota(); n++) step();
    chk("abort_reach_quota", at_quota(), 1);
    ctrl_abort = 1'b1;
    step();
    ctrl_abort = 1'b0;
    for (int i = 0; i < 4; i++) quota[i] = 1000;
    run_to_done(200);
    chk_acc("abort", 10, 10, 10, 10);
    chk("abort_out", out_m, 10);
    chk("abort_aborted", last_aborted, 1);
    chk("abort_error", error_desync, 0);

    // Aligned word in IDLE flags desync; next start clears it
    force_avail = 1'b1;
    step();
    force_avail = 1'b0;
    chk("err_set", error_desync, 1);
    step();
    chk("err_sticky", error_desync, 1);
    start(0);
    chk("err_clear", error_desync, 0);
    step();

    // Reset mid-RUN, then a short batch
    start(100);
    for (int n = 0; n < 200 && acc_m[0] < 40; n++) step();
    chk("mid_acc0", acc_m[0], 40);
    s_rst_n    = 1'b0;
    aligner_on = 1'b0;
    step();
    s_rst_n    = 1'b1;
    aligner_on = 1'b1;
    chk("mid_rst_busy", ctrl_busy, 0);
    chk("mid_rst_src_rdy", src_rdy, 0);
    chk("mid_rst_aln_vld", aln_vld, 0);
    chk("mid_rst_done", ctrl_done, 0);
    chk("mid_rst_aborted", ctrl_aborted, 0);
    chk("mid_rst_error", error_desync, 0);
    chk("mid_rst_perf", perf_stall, 0);
    start(5);
    run_to_done(100);
    chk_acc("post", 5, 5, 5, 5);
    chk("post_out", out_m, 5);
    chk("post_aborted", last_aborted, 0);
    chk("post_error", error_desync, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_align_ctrl.md
# stream_align_ctrl

Batch scheduler and skew limiter placed between IN_NB independent lane sources and a stream-to-pipe aligner. It runs batches of a programmed number of words. For each batch it gates every lane's valid/ready so that no lane runs more than DEPTH words ahead of the aligned output, which keeps the aligner from overflowing. It also supports abort with lane re-equalisation and reports a sticky alignment error.

## Interface
- IN_NB, 4, number of lanes
- DEPTH, 8, maximum lead in words of any lane over the aligned output count; must equal the aligner depth
- CNT_W, 16, width of the batch length and all counters

Ports:
- clk  in  1  clock
- s_rst_n  in  1  reset: synchronous, active-low
- ctrl_start  in  1  pulse; starts a batch, sampled only in IDLE
- ctrl_len  in  CNT_W  batch length in aligned words, captured with ctrl_start
- ctrl_abort  in  1  pulse; honoured only in RUN
- ctrl_busy  out  1  high in every state except IDLE
- ctrl_done  out  1  one-cycle end-of-batch pulse
- ctrl_aborted  out  1  qualifies ctrl_done; high if the batch was aborted
- src_vld  in  IN_NB  lane valid from the sources
- src_rdy  out  IN_NB  lane ready to the sources
- aln_vld  out  IN_NB  lane valid to the aligner
- aln_rdy  in  IN_NB  lane ready from the aligner
- aln_avail  in  1  aligned-word pulse from the aligner
- error_desync  out  1  sticky error flag
- perf_stall  out  32  lead-limit stall cycle count (see Configuration)

## Operation
- Lane gating is combinational on registered state: aln_vld[i] = src_vld[i] & en[i]; src_rdy[i] = aln_rdy[i] & en[i].
- Lane handshake: acc[i] increments when src_vld[i] & src_rdy[i].
- Aligned output count: out_cnt increments on each aln_avail.
- lead[i] = acc[i] − out_cnt, in the range 0..DEPTH. Subtraction is CNT_W-bit unsigned with no wrap, because acc[i] ≥ out_cnt.
- States:
  - IDLE: en = 0. On ctrl_start, capture len = ctrl_len and clear acc, out_cnt and error_desync. If len = 0, go to DONE; otherwise go to RUN.
  - RUN: en[i] = (acc[i] < len) & (lead[i] < DEPTH).
    - If ctrl_abort is high, go to EQUALIZE. Abort has priority over normal completion in the same cycle.
    - Else, if all acc[i] = len, go to DRAIN.
  - DRAIN: en = 0. When out_cnt = len, go to DONE.
  - EQUALIZE: tgt = max over i of acc[i], frozen on entry. en[i] = (acc[i] < tgt). When all acc[i] = tgt, go to DRAIN with len replaced by tgt.
  - DONE: ctrl_done = 1 for one cycle, ctrl_aborted = (batch was aborted). Then go to IDLE.
- error_desync is set when aln_avail arrives in IDLE, or when aln_avail arrives with out_cnt = min over i of acc[i] (aligned output before every lane supplied a word). It clears only on reset or ctrl_start.
- ctrl_start outside IDLE and ctrl_abort outside RUN are ignored.

## Timing
- Reset values: state IDLE; all counters 0; src_rdy = 0; aln_vld = 0; ctrl_busy = 0; ctrl_done = 0; ctrl_aborted = 0; error_desync = 0; perf_stall = 0.
- ctrl_busy rises the cycle after an accepted ctrl_start.
- With ctrl_len = 0, ctrl_done pulses 1 cycle after ctrl_start.
- A lane at lead = DEPTH−1 that handshakes has en = 0 on the next cycle. Its en returns the cycle after aln_avail.
- acc[i] and out_cnt update in the same cycle. A lane handshake and aln_avail in the same cycle leave lead[i] unchanged.
- ctrl_done asserts the cycle after out_cnt reaches len. ctrl_busy falls the cycle after ctrl_done.
- Reset mid-batch returns to IDLE with all outputs at their reset values. There is no partial-batch memory.

## Configuration
- STREAM_ALIGN_CTRL_PERF_EN defined:
  - perf_stall counts cycles in RUN where some lane has src_vld[i] = 1, acc[i] < len and lead[i] = DEPTH.
  - The counter saturates at 2^32−1 and clears on ctrl_start.
- Undefined: perf_stall is tied to 0 and no counter logic is built.

## Test plan
- Nominal batch: IN_NB = 4, DEPTH = 8, len = 100, all sources always valid, aligner echoes one aln_avail per complete column → exactly 100 handshakes per lane; ctrl_done pulses once with ctrl_aborted = 0; error_desync = 0.
- Lead limit: lane 0 always valid, lanes 1–3 held invalid → lane 0 stops at acc = 8; src_rdy[0] stays 0 until lanes 1–3 supply and aln_avail pulses. With PERF_EN, perf_stall > 0.
- Abort with skew: len = 50, abort when acc = {10, 7, 9, 10} → EQUALIZE accepts 3, 1 and 0 more words on lanes 1, 2 and 3; ctrl_done pulses with ctrl_aborted = 1 after out_cnt = 10.
- Zero length: ctrl_len = 0 → ctrl_done one cycle after start; no lane enabled.
- Error: aln_avail injected in IDLE → error_desync = 1; the next ctrl_start clears it.
- Reset mid-RUN at acc = 40 → all outputs return to reset values; the following batch with len = 5 completes normally.
